pdw_rx_deser: RTL
=================

Name: pdw_rx_deser

Overview:
- Receives the serial pulse-descriptor-word stream (`pdw_data`/`pdw_frame`) from the FIR snapshot transmitter.
- Deserialises each frame into 16-bit words and buffers them in a show-ahead FIFO.
- Presents the words on a valid/ready stream, with per-frame status, length/overflow/CRC error flags and a good-frame counter.
- Sits on the capture/test side directly downstream of the snapshot TX, in the same `clk` domain.

Parameters:
- WORD_WIDTH, 16, output word width and deserialiser shift length.
- FRAME_BITS, 192, payload bits per frame (10 samples x 16 + 32-bit timestamp); must be a multiple of WORD_WIDTH.
- FIFO_DEPTH, 16, word FIFO depth; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pdw_data  in  1  serial data, MSB first, sampled on posedge clk while `pdw_frame`=1.
- pdw_frame  in  1  frame envelope; high for the whole frame.
- m_data  out  WORD_WIDTH  head-of-FIFO word.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts; a pop happens when `m_valid` & `m_ready`.
- m_last  out  1  head word is the final payload word of its frame.
- frame_done  out  1  one-cycle pulse at end of every frame.
- frame_err  out  1  one-cycle pulse with `frame_done` when that frame had any error.
- err_len  out  1  sticky: wrong bit count seen.
- err_ovf  out  1  sticky: word dropped because the FIFO was full.
- err_crc  out  1  sticky: CRC mismatch (feature only).
- clr_status  in  1  clears all sticky flags.
- frame_count  out  16  count of error-free frames; wraps 0xFFFF->0.

Behaviour:
- Reset values:
  - `m_valid`=0, `m_last`=0, `frame_done`=0, `frame_err`=0.
  - All sticky flags 0, `frame_count`=0.
  - FIFO emptied, bit counter 0.
  - State goes to SYNC.
- FSM states: SYNC, IDLE, RECV, DROP.
  - SYNC: wait for `pdw_frame`=0, then go to IDLE. Prevents capturing a frame that was already in progress at reset release.
  - IDLE: `pdw_frame`=1 goes to RECV. The bit on that same edge is payload bit 0.
  - RECV: each edge with `pdw_frame`=1 shifts `pdw_data` into the LSB of the shift register and increments the bit count.
  - RECV, word completion: when bit_count mod 16 reaches 15 on an edge, the word {sr[14:0], pdw_data} is written to the FIFO on that same edge. `m_valid` rises after that edge, so latency is 1 cycle.
  - RECV, final payload word: the word is tagged last (FIFO carries WORD_WIDTH+1 bits).
  - RECV, too many bits: if `pdw_frame` is still 1 once the expected bits are received, set `err_len` and go to DROP. Extra bits are discarded.
  - RECV, frame end: `pdw_frame`=0 ends the frame.
    - If the bit count equals the expected total, the frame is good.
    - Otherwise it is short: set `err_len` and discard the partial word. Words already written stay in the FIFO, and no last tag is issued.
  - DROP: ignore data until `pdw_frame`=0.
  - End of frame (the edge where `pdw_frame` is sampled 0 in RECV or DROP): pulse `frame_done` and return to IDLE.
    - If the frame had any error, `frame_err` pulses with `frame_done`.
    - Otherwise `frame_count` increments.
- Frame spacing: one low cycle between frames is sufficient; back-to-back frames must both be received.
- FIFO full when a word completes: the word is dropped, `err_ovf` is set and the frame is marked errored. Bit counting continues.
- Simultaneous push and pop with the FIFO full: the pop frees a slot and the push is accepted with no overflow.
- `clr_status` together with a new error event on the same edge: the error wins and the flag stays 1.
- `m_data` and `m_last` are held stable while `m_valid`=1 and `m_ready`=0.
- `rst` asserted mid-frame: FIFO flushed and state goes to SYNC. The remainder of the current frame is ignored, and no `frame_done` is issued for it.

Optional Feature:
- Macro: PDW_RX_CRC_EN.
- Defined:
  - The frame carries FRAME_BITS payload followed by 16 CRC bits, so the expected total is FRAME_BITS+16.
  - CRC is CRC-16-CCITT: polynomial 0x1021, init 0xFFFF, computed bit-serially over payload bits MSB first, no reflection, no final XOR.
  - CRC bits are not written to the FIFO.
  - At frame end, a mismatch against the received CRC sets `err_crc` and marks the frame errored.
  - A frame that is not the correct length does not set `err_crc`.
- Undefined:
  - Expected total is FRAME_BITS, no CRC logic is built, and `err_crc` is tied 0.

Test Plan:
- Reset, then a 192-bit frame of words 0x0001..0x000C -> 12 words out in order, `m_last` only on 0x000C, `frame_done`=1 with `frame_err`=0, `frame_count`=1.
- Frame cut to 100 bits -> 6 words out, no `m_last`, `err_len`=1, `frame_err` pulse, `frame_count` unchanged; `clr_status` then clears `err_len`.
- Frame of 200 bits -> 12 words with last on word 12, `err_len`=1, `frame_err` pulse.
- `m_ready`=0 held, FIFO_DEPTH=16, two back-to-back frames (24 words) with a 1-cycle gap -> first 16 words kept, `err_ovf`=1, second frame errored; draining returns the first 16 in order.
- `rst` at bit 50 with `pdw_frame` still high -> FIFO empty, no `frame_done` for the cut frame, next full frame received correctly.
- With PDW_RX_CRC_EN, a payload of twelve 0x0000 words plus a correct CRC -> `frame_err`=0; the same payload with one CRC bit flipped -> `err_crc`=1, `frame_err` pulse.

Source files
------------

// File: rtl/pdw_rx_deser.sv
// Serial PDW frame receiver: deserialises frames into WORD_WIDTH words through a show-ahead FIFO.
// Optional CRC-16-CCITT trailer check is built when PDW_RX_CRC_EN is defined.
module pdw_rx_deser #(
  parameter int WORD_WIDTH = 16,
  parameter int FRAME_BITS = 192,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pdw_data,
  input  logic                  pdw_frame,
  output logic [WORD_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic                  err_len,
  output logic                  err_ovf,
  output logic                  err_crc,
  input  logic                  clr_status,
  output logic [15:0]           frame_count
);

`ifdef PDW_RX_CRC_EN
  localparam int TOTAL_BITS = FRAME_BITS + 16;
`else
  localparam int TOTAL_BITS = FRAME_BITS;
`endif
  localparam int CW  = $clog2(TOTAL_BITS + 1);
  localparam int WBW = $clog2(WORD_WIDTH);
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {SYNC, IDLE, RECV, DROP} state_t;

  typedef struct packed {
    logic                  last;
    logic [WORD_WIDTH-1:0] data;
  } fifo_ent_t;

  state_t state, state_nx;

  logic [CW-1:0]         bit_cnt;
  logic [WBW-1:0]        wbit;
  logic [WORD_WIDTH-2:0] sr;
  logic                  frm_bad;

  logic take_bit, too_long, frame_end, len_short, crc_bad, bad_now;
  logic in_payload, word_done, word_last;

  fifo_ent_t        mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, pop, push, ovf;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= SYNC;
    else     state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      SYNC: if (!pdw_frame) state_nx = IDLE;
      IDLE: if (pdw_frame)  state_nx = RECV;
      RECV: begin
        if (!pdw_frame)                       state_nx = IDLE;
        else if (bit_cnt == CW'(TOTAL_BITS))  state_nx = DROP;
      end
      DROP: if (!pdw_frame) state_nx = IDLE;
      default: state_nx = SYNC;
    endcase
  end

  // FSM: control outputs
  always_comb begin
    take_bit  = 1'b0;
    too_long  = 1'b0;
    frame_end = 1'b0;
    len_short = 1'b0;
    case (state)
      IDLE: take_bit = pdw_frame;
      RECV: begin
        if (pdw_frame) begin
          take_bit = (bit_cnt != CW'(TOTAL_BITS));
          too_long = (bit_cnt == CW'(TOTAL_BITS));
        end else begin
          frame_end = 1'b1;
          len_short = (bit_cnt != CW'(TOTAL_BITS));
        end
      end
      DROP: frame_end = !pdw_frame;
      default: ;
    endcase
  end

  assign in_payload = (bit_cnt < CW'(FRAME_BITS));
  assign word_done  = take_bit && in_payload && (wbit == WBW'(WORD_WIDTH - 1));
  assign word_last  = (bit_cnt == CW'(FRAME_BITS - 1));

`ifdef PDW_RX_CRC_EN
  logic [15:0] crc, rx_crc;
  logic        crc_fb;

  assign crc_fb  = crc[15] ^ pdw_data;
  // Only a correctly sized frame is judged on its CRC.
  assign crc_bad = frame_end && (state == RECV) && !len_short && (crc != rx_crc);

  always_ff @(posedge clk) begin
    if (rst) begin
      crc    <= 16'hFFFF;
      rx_crc <= '0;
    end else if (frame_end) begin
      crc    <= 16'hFFFF;
    end else if (take_bit) begin
      rx_crc <= {rx_crc[14:0], pdw_data};
      if (in_payload) crc <= {crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          err_crc <= 1'b0;
    else if (crc_bad) err_crc <= 1'b1;
    else if (clr_status) err_crc <= 1'b0;
  end
`else
  assign crc_bad = 1'b0;
  assign err_crc = 1'b0;
`endif

  assign bad_now = frm_bad | len_short | crc_bad;

  // Deserialiser, frame status and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      wbit        <= '0;
      sr          <= '0;
      frm_bad     <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
      err_len     <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      frame_done <= frame_end;
      frame_err  <= frame_end && bad_now;
      if (take_bit) begin
        sr      <= {sr[WORD_WIDTH-3:0], pdw_data};
        bit_cnt <= bit_cnt + CW'(1);
        wbit    <= (wbit == WBW'(WORD_WIDTH - 1)) ? '0 : wbit + WBW'(1);
      end
      if (frame_end) begin
        bit_cnt <= '0;
        wbit    <= '0;
        frm_bad <= 1'b0;
        if (!bad_now) frame_count <= frame_count + 16'd1;
      end else if (ovf || too_long) begin
        frm_bad <= 1'b1;
      end
      // A new error event on the same edge as clr_status keeps the flag set.
      err_len <= (too_long | len_short) | (err_len & ~clr_status);
      err_ovf <= ovf | (err_ovf & ~clr_status);
    end
  end

  // Show-ahead word FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop  = m_valid && m_ready;
  assign push = word_done && (!full || pop);
  assign ovf  = word_done && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{last: word_last, data: {sr, pdw_data}};
  end

  assign m_valid = (wr_ptr != rd_ptr);
  assign m_data  = mem[rd_ptr[AW-1:0]].data;
  assign m_last  = m_valid && mem[rd_ptr[AW-1:0]].last;

endmodule
